// File: rtl/eth_tx_arb_if.sv
// Byte-stream bundle between the frame sources, the arbiter and the MAC.
// master is the arbiter's view; slave is the surrounding sources and MAC.
interface eth_tx_arb_if #(
   parameter int NUM_PORTS = 3
) ();
   logic [NUM_PORTS-1:0]   s_tx_vld;
   logic [8*NUM_PORTS-1:0] s_tx_dat;
   logic [NUM_PORTS-1:0]   s_tx_sof;
   logic [NUM_PORTS-1:0]   s_tx_eof;
   logic [NUM_PORTS-1:0]   s_tx_ack;
   logic                   m_tx_vld;
   logic [7:0]             m_tx_dat;
   logic                   m_tx_sof;
   logic                   m_tx_eof;
   logic                   m_tx_ack;

   modport master (
      input  s_tx_vld,
      input  s_tx_dat,
      input  s_tx_sof,
      input  s_tx_eof,
      output s_tx_ack,
      output m_tx_vld,
      output m_tx_dat,
      output m_tx_sof,
      output m_tx_eof,
      input  m_tx_ack
   );

   modport slave (
      output s_tx_vld,
      output s_tx_dat,
      output s_tx_sof,
      output s_tx_eof,
      input  s_tx_ack,
      input  m_tx_vld,
      input  m_tx_dat,
      input  m_tx_sof,
      input  m_tx_eof,
      output m_tx_ack
   );
endinterface

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter onto one MAC tx byte stream.
// Flushes stray idle bytes, gates new frames on link, counts frames.
module eth_tx_arb #(
   parameter int NUM_PORTS = 3,
   parameter int CNT_W     = 16
) (
   input  logic                       clk_mac,
   input  logic                       rst,
   input  logic                       link_up,
   eth_tx_arb_if.master               bus,
   output logic [NUM_PORTS-1:0]       grant,
   output logic                       busy,
   output logic                       flush_err,
   output logic [CNT_W*NUM_PORTS-1:0] frame_cnt
);
   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                          state_q, state_d;
   logic [NUM_PORTS-1:0]            grant_q, grant_d;
   logic [IDX_W-1:0]                owner_q, owner_d;
   logic [IDX_W-1:0]                last_q, last_d;
   logic                            flush_q, flush_d;
   logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] stray;
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     cand;
   logic                 eof_xfer;

   assign elig  = bus.s_tx_vld & bus.s_tx_sof
                & {NUM_PORTS{link_up}};
   assign stray = bus.s_tx_vld & ~bus.s_tx_sof;

   assign eof_xfer = bus.s_tx_vld[owner_q]
                   & bus.m_tx_ack
                   & bus.s_tx_eof[owner_q];

   // Search starts just after the previous winner, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = IDX_W'((int'(last_q) + k) % NUM_PORTS);
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk_mac) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDX_W'(NUM_PORTS - 1);
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      flush_d = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            flush_d = |stray;
            if (win_found) begin
               state_d = LOCK;
               owner_d = win_idx;
               grant_d = NUM_PORTS'(1) << win_idx;
            end
         end
         LOCK: begin
            if (eof_xfer) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = owner_q;
               cnt_d[owner_q] = cnt_q[owner_q]
                              + CNT_W'(1);
            end
         end
      endcase
   end

   // LOCK is a zero-latency pass-through of the owning port.
   always_comb begin
      bus.m_tx_vld = 1'b0;
      bus.m_tx_dat = '0;
      bus.m_tx_sof = 1'b0;
      bus.m_tx_eof = 1'b0;
      bus.s_tx_ack = '0;
      unique case (state_q)
         IDLE: begin
            bus.s_tx_ack = stray;
         end
         LOCK: begin
            bus.m_tx_vld = bus.s_tx_vld[owner_q];
            bus.m_tx_dat = bus.s_tx_dat[8*owner_q +: 8];
            bus.m_tx_sof = bus.s_tx_sof[owner_q];
            bus.m_tx_eof = bus.s_tx_eof[owner_q];
            bus.s_tx_ack[owner_q] = bus.m_tx_ack;
         end
      endcase
   end

   assign grant     = grant_q;
   assign busy      = (state_q == LOCK);
   assign flush_err = flush_q;
   assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: vector table, directed corner sequences and
// randomized traffic against a frame-level reference model.
module tb_eth_tx_arb;
   localparam int N  = 3;
   localparam int CW = 4;
   localparam int DW = 8 * N;

   logic          clk_mac = 1'b0;
   logic          rst;
   logic          link_up;
   logic [N-1:0]  grant;
   logic          busy;
   logic          flush_err;
   logic [CW*N-1:0] frame_cnt;

   eth_tx_arb_if #(.NUM_PORTS(N)) bus ();

   eth_tx_arb #(.NUM_PORTS(N), .CNT_W(CW)) dut (
      .clk_mac  (clk_mac),
      .rst      (rst),
      .link_up  (link_up),
      .bus      (bus),
      .grant    (grant),
      .busy     (busy),
      .flush_err(flush_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk_mac = ~clk_mac;

   int errs   = 0;
   int checks = 0;

   int m_owner;
   int m_last;
   int m_cnt [N];
   bit m_flush;

   typedef struct {
      logic [N-1:0] vld, sof, eof;
      logic [7:0]   dat;
      logic         mack;
      logic [N-1:0] e_grant;
      logic         e_mvld, e_msof, e_meof;
      logic [7:0]   e_mdat;
      logic [N-1:0] e_sack;
      logic         e_flush;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [N-1:0] v, input logic [N-1:0] s,
                        input logic [N-1:0] e, input logic [7:0] d,
                        input logic mk);
      bus.s_tx_vld = v;
      bus.s_tx_sof = s;
      bus.s_tx_eof = e;
      bus.s_tx_dat = {N{d}};
      bus.m_tx_ack = mk;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_mac);
      #1;
   endtask

   function automatic logic [CW-1:0] cnt_of(input int i);
      return frame_cnt[CW*i +: CW];
   endfunction

   task automatic do_reset();
      rst     = 1'b1;
      link_up = 1'b1;
      apply('0, '0, '0, 8'h00, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      m_owner = -1;
      m_last  = N - 1;
      m_flush = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic send1(input int p);
      logic [N-1:0] b;
      b = N'(1) << p;
      apply(b, b, b, 8'h11, 1'b1);
      tick();
      apply(b, b, b, 8'h11, 1'b1);
      tick();
   endtask

   task automatic rand_run(input int ncyc);
      logic [N-1:0]    v, s, e, ea;
      logic [DW-1:0]   d;
      logic            mk;
      logic [CW*N-1:0] ec;
      int              o;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(0, 3) != 0);
            s[i] = ($urandom_range(0, 9) < 4);
            e[i] = ($urandom_range(0, 9) < 3);
         end
         d       = DW'($urandom);
         mk      = ($urandom_range(0, 3) != 0);
         link_up = ($urandom_range(0, 9) != 0);
         bus.s_tx_vld = v;
         bus.s_tx_sof = s;
         bus.s_tx_eof = e;
         bus.s_tx_dat = d;
         bus.m_tx_ack = mk;
         #1;
         o = m_owner;
         chk("rnd_grant", grant, (o < 0) ? 0 : (1 << o));
         chk("rnd_busy", busy, (o >= 0));
         chk("rnd_flush", flush_err, m_flush);
         if (o < 0) begin
            chk("rnd_mvld", bus.m_tx_vld, 0);
            chk("rnd_mdat", bus.m_tx_dat, 0);
            chk("rnd_sack", bus.s_tx_ack, v & ~s);
         end else begin
            ea    = '0;
            ea[o] = mk;
            chk("rnd_mvld", bus.m_tx_vld, v[o]);
            chk("rnd_mdat", bus.m_tx_dat, d[8*o +: 8]);
            chk("rnd_msof", bus.m_tx_sof, s[o]);
            chk("rnd_meof", bus.m_tx_eof, e[o]);
            chk("rnd_sack", bus.s_tx_ack, ea);
         end
         ec = '0;
         for (int i = 0; i < N; i++) ec[CW*i +: CW] = CW'(m_cnt[i]);
         chk("rnd_cnt", frame_cnt, ec);
         if (o < 0) begin
            m_flush = |(v & ~s);
            for (int k = 1; k <= N; k++) begin
               int p;
               p = (m_last + k) % N;
               if (m_owner < 0 && link_up && v[p] && s[p])
                  m_owner = p;
            end
         end else begin
            m_flush = 1'b0;
            if (v[o] && mk && e[o]) begin
               m_cnt[o] = (m_cnt[o] + 1) % (1 << CW);
               m_last   = o;
               m_owner  = -1;
            end
         end
         tick();
      end
   endtask

   initial begin
      int pulses;
      logic [N-1:0] b;
      logic [N-1:0] sv;
      int bidx [7];
      logic mks [7];

      tbl[0] = '{3'b010, 3'b010, 3'b000, 8'hA0, 1'b1,
                 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0};
      tbl[1] = '{3'b010, 3'b010, 3'b000, 8'hA0, 1'b1,
                 3'b010, 1'b1, 1'b1, 1'b0, 8'hA0, 3'b010, 1'b0};
      tbl[2] = '{3'b011, 3'b000, 3'b000, 8'hA1, 1'b1,
                 3'b010, 1'b1, 1'b0, 1'b0, 8'hA1, 3'b010, 1'b0};
      tbl[3] = '{3'b010, 3'b000, 3'b000, 8'hA2, 1'b0,
                 3'b010, 1'b1, 1'b0, 1'b0, 8'hA2, 3'b000, 1'b0};
      tbl[4] = '{3'b010, 3'b000, 3'b000, 8'hA2, 1'b1,
                 3'b010, 1'b1, 1'b0, 1'b0, 8'hA2, 3'b010, 1'b0};
      tbl[5] = '{3'b010, 3'b000, 3'b010, 8'hA3, 1'b1,
                 3'b010, 1'b1, 1'b0, 1'b1, 8'hA3, 3'b010, 1'b0};
      tbl[6] = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b1,
                 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0};
      tbl[7] = '{3'b001, 3'b000, 3'b000, 8'h55, 1'b1,
                 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b001, 1'b0};
      tbl[8] = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0,
                 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1};
      tbl[9] = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0,
                 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0};

      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush", flush_err, 0);
      chk("rst_mvld", bus.m_tx_vld, 0);
      chk("rst_mdat", bus.m_tx_dat, 0);
      chk("rst_cnt", frame_cnt, 0);

      for (int r = 0; r < 10; r++) begin
         apply(tbl[r].vld, tbl[r].sof, tbl[r].eof,
               tbl[r].dat, tbl[r].mack);
         chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_grant);
         chk($sformatf("tbl%0d_busy", r), busy, |tbl[r].e_grant);
         chk($sformatf("tbl%0d_mvld", r), bus.m_tx_vld, tbl[r].e_mvld);
         chk($sformatf("tbl%0d_msof", r), bus.m_tx_sof, tbl[r].e_msof);
         chk($sformatf("tbl%0d_meof", r), bus.m_tx_eof, tbl[r].e_meof);
         chk($sformatf("tbl%0d_mdat", r), bus.m_tx_dat, tbl[r].e_mdat);
         chk($sformatf("tbl%0d_sack", r), bus.s_tx_ack, tbl[r].e_sack);
         chk($sformatf("tbl%0d_flush", r), flush_err, tbl[r].e_flush);
         tick();
      end
      chk("tbl_cnt1", cnt_of(1), 1);

      do_reset();
      for (int k = 0; k < 6; k++) begin
         b = N'(1) << (k % N);
         apply(3'b111, 3'b111, 3'b000, 8'h30, 1'b1);
         chk("rr_idle_grant", grant, 0);
         chk("rr_idle_sack", bus.s_tx_ack, 0);
         tick();
         apply(3'b111, 3'b111, 3'b000, 8'h31, 1'b1);
         chk($sformatf("rr%0d_grant", k), grant, b);
         chk("rr_msof", bus.m_tx_sof, 1);
         chk("rr_sack", bus.s_tx_ack, b);
         tick();
         apply(3'b111, 3'b111 & ~b, b, 8'h32, 1'b1);
         chk("rr_meof", bus.m_tx_eof, 1);
         tick();
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("rr_cnt%0d", i), cnt_of(i), 2);

      do_reset();
      link_up = 1'b0;
      for (int c = 0; c < 20; c++) begin
         apply(3'b100, 3'b100, 3'b000, 8'h70, 1'b1);
         chk("lnk_grant", grant, 0);
         chk("lnk_sack", bus.s_tx_ack, 0);
         tick();
      end
      link_up = 1'b1;
      apply(3'b100, 3'b100, 3'b000, 8'h70, 1'b1);
      tick();
      apply(3'b100, 3'b100, 3'b100, 8'h77, 1'b1);
      chk("lnk_grant_up", grant, 3'b100);
      chk("lnk_mdat", bus.m_tx_dat, 8'h77);
      chk("lnk_meof", bus.m_tx_eof, 1);
      tick();
      apply('0, '0, '0, 8'h00, 1'b1);
      chk("lnk_done_grant", grant, 0);
      chk("lnk_cnt2", cnt_of(2), 1);

      do_reset();
      pulses = 0;
      for (int j = 0; j < 6; j++) begin
         b = (j < 3) ? 3'b001 : 3'b000;
         apply(b, 3'b000, 3'b000, 8'hF0, 1'b1);
         chk("fl_sack", bus.s_tx_ack, b);
         chk("fl_mvld", bus.m_tx_vld, 0);
         if (flush_err) pulses++;
         tick();
      end
      chk("fl_pulses", pulses, 3);
      chk("fl_cnt0", cnt_of(0), 0);

      do_reset();
      bidx = '{0, 1, 1, 2, 2, 3, 3};
      mks  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      apply(3'b010, 3'b010, 3'b000, 8'hB0, 1'b1);
      tick();
      for (int j = 0; j < 7; j++) begin
         if (j >= 3) link_up = 1'b0;
         sv = 3'b101 | ((bidx[j] == 0) ? 3'b010 : 3'b000);
         apply(3'b111, sv, (bidx[j] == 3) ? 3'b010 : 3'b000,
               8'hB0 + 8'(bidx[j]), mks[j]);
         chk("ak_grant", grant, 3'b010);
         chk("ak_mdat", bus.m_tx_dat, 8'hB0 + 8'(bidx[j]));
         chk("ak_sack", bus.s_tx_ack, mks[j] ? 3'b010 : 3'b000);
         tick();
      end
      apply(3'b101, 3'b101, 3'b000, 8'h00, 1'b1);
      chk("ak_end_grant", grant, 0);
      chk("ak_cnt1", cnt_of(1), 1);
      tick();
      chk("ak_nolink_grant", grant, 0);
      link_up = 1'b1;

      do_reset();
      for (int f = 0; f < 15; f++) send1(0);
      chk("wr_cnt15", cnt_of(0), 15);
      send1(0);
      chk("wr_cnt0", cnt_of(0), 0);
      send1(0);
      chk("wr_cnt1", cnt_of(0), 1);
      apply(3'b010, 3'b010, 3'b000, 8'h20, 1'b1);
      tick();
      apply(3'b010, 3'b000, 3'b000, 8'h22, 1'b0);
      chk("mr_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_grant", grant, 0);
      chk("mr_busy0", busy, 0);
      chk("mr_cnt", frame_cnt, 0);
      chk("mr_mvld", bus.m_tx_vld, 0);

      do_reset();
      rand_run(2000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Frame-granular round-robin arbiter that shares the single MAC transmit byte stream (tx_vld/tx_dat/tx_sof/tx_eof/tx_ack) between N frame sources, e.g. ARP responder, UDP stack and a debug injector.
- Sits in the clk_mac domain between the sources and the MAC tx port.
- Gates new frames on link state, flushes stray mid-frame bytes and keeps per-port sent-frame counters.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- CNT_W, 16, width of each per-port frame counter.

Ports:
- clk_mac  input  1  MAC clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- link_up  input  1  PHY link status from the configuration block.
- s_tx_vld  input  NUM_PORTS  per-port byte valid.
- s_tx_dat  input  8*NUM_PORTS  per-port byte; port i occupies bits [8i+7:8i].
- s_tx_sof  input  NUM_PORTS  per-port first byte of frame.
- s_tx_eof  input  NUM_PORTS  per-port last byte of frame.
- s_tx_ack  output  NUM_PORTS  per-port byte consumed.
- m_tx_vld  output  1  to MAC tx_vld.
- m_tx_dat  output  8  to MAC tx_dat.
- m_tx_sof  output  1  to MAC tx_sof.
- m_tx_eof  output  1  to MAC tx_eof.
- m_tx_ack  input  1  from MAC tx_ack.
- grant  output  NUM_PORTS  one-hot owner of the MAC; zero when idle.
- busy  output  1  high while in LOCK.
- flush_err  output  1  one-cycle pulse when a stray byte is discarded.
- frame_cnt  output  CNT_W*NUM_PORTS  per-port completed-frame counters; wrap at 2^CNT_W.

Behaviour:
- Transfer rule: a byte moves on any cycle with vld && ack, on either side.
- Reset values:
  - state=IDLE, grant=0, busy=0, flush_err=0, frame_cnt all 0.
  - last_winner=NUM_PORTS-1, so port 0 has first priority.
  - m_tx_vld/sof/eof=0, m_tx_dat=0.
- State IDLE:
  - m_tx_vld=0.
  - A port is eligible when s_tx_vld[i] && s_tx_sof[i] && link_up.
  - Winner = first eligible port searching last_winner+1 upward with wrap modulo NUM_PORTS.
  - grant is registered; transition to LOCK next cycle. Arbitration latency is 1 cycle; the sof byte is not acked in IDLE.
  - Flush: any port with s_tx_vld && !s_tx_sof gets s_tx_ack=1 in the same cycle, independent of link_up. flush_err pulses the next cycle if any port flushed.
  - link_up=0: no grant is issued; sof bytes are held (not acked) and the sources stall.
- State LOCK, granted port g, zero-latency combinational pass-through:
  - m_tx_vld=s_tx_vld[g], m_tx_dat/sof/eof = port g's fields.
  - s_tx_ack[g]=m_tx_ack; all other s_tx_ack=0 (no flushing in LOCK).
  - When m_tx_vld && m_tx_ack && m_tx_eof: next cycle state=IDLE, grant=0, last_winner=g, frame_cnt[g] += 1 (wraps).
  - link_up falling mid-frame: frame continues to eof; link only gates new grants.
  - sof re-asserted mid-frame by g is forwarded unchanged; only eof ends ownership.
  - A single-byte frame (sof&&eof) completes in one LOCK cycle.
- Minimum inter-frame spacing at the arbiter: 1 IDLE cycle between eof transfer and the next sof transfer.
- Same port requesting back-to-back while another port is eligible: the other port wins. A lone requester wins repeatedly.
- rst asserted mid-frame: state returns to IDLE immediately; the partial frame is abandoned (MAC sees vld drop); counters cleared.
- m_tx_ack high with m_tx_vld low: ignored.

Test Plan:
- Reset then port1 frame of 4 bytes, link_up=1, m_tx_ack=1 -> grant=3'b010 on cycle 2; 4 bytes out on cycles 2-5 in order with sof on byte 0 and eof on byte 3; frame_cnt[1]=1; grant=0 on cycle 6.
- Ports 0,1,2 all hold sof continuously, each sending 2-byte frames -> grant order 0,1,2,0,1,2; each frame_cnt=2 after 6 frames; 1 idle cycle between frames.
- link_up=0 with port 2 holding sof -> no ack, grant=0 for 20 cycles; link_up=1 -> grant=3'b100 next cycle, frame delivered.
- Port 0 presents 3 bytes with no sof while idle -> each acked on its cycle, flush_err pulses 3 times, m_tx_vld stays 0, frame_cnt unchanged.
- During port 1's frame, m_tx_ack toggles 1,0,1,0 and link_up drops after byte 1 -> each byte is held until acked, frame completes to eof, and s_tx_ack[0]=s_tx_ack[2]=0 throughout.
- frame_cnt[0] preloaded to 0xFFFF via 65535 frames (or CNT_W=4 with 15 frames) -> the next frame wraps it to 0; rst mid-frame -> grant=0, busy=0, counters 0 on the next cycle.
